interval_capture: RTL

- Measures the interval between a start event and a stop event, in enabled clock ticks, and reports it as a WIDTH-bit value with a valid strobe.
- It is the inverse of the countdown timer: the timer turns a loaded value into a delay, and this block turns a delay back into a value.
- It sits beside the timer in the peripheral set. Software or an FSM reads the captured value, for example to reload a timer with a measured period.

---
 rtl/interval_capture_if.sv | 24 ++
 rtl/interval_capture.sv | 125 ++++++++++++
 2 files changed

// File: rtl/interval_capture_if.sv
// Bundles the event inputs and capture outputs of interval_capture.
interface interval_capture_if #(
    parameter int WIDTH = 5
);
    logic             enable;
    logic             start;
    logic             stop;
    logic             ack;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             busy;
    logic             overflow;
    logic             lost;

    modport master (
        output enable, start, stop, ack,
        input  value, valid, busy, overflow, lost
    );

    modport slave (
        input  enable, start, stop, ack,
        output value, valid, busy, overflow, lost
    );
endinterface

// File: rtl/interval_capture.sv
// Counts enabled ticks between start and stop and captures the interval, saturating at 2^WIDTH-1.
// Define CAPTURE_ACK_EN to hold valid until ack and flag stops dropped while unacknowledged.
module interval_capture #(
    parameter int WIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    interval_capture_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SAT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_next;
    logic             valid_q;
    logic             valid_next;
    logic             overflow_q;
    logic             overflow_next;
    logic             lost_q;
    logic             lost_next;
    logic [WIDTH:0]   sum;
    logic             reach;
    logic             sum_hit;
    logic             capture;
    logic             accept;

    // One extra bit so the add can never wrap before it is clamped.
    assign sum     = {1'b0, count} + {{WIDTH{1'b0}}, bus.enable};
    assign reach   = (sum >= {1'b0, MAX});
    assign sum_hit = (state == SAT) || reach;
    assign capture = (state != IDLE) && bus.stop;

`ifdef CAPTURE_ACK_EN
    assign accept = capture && !(valid_q && !bus.ack);
`else
    logic unused_ack;
    assign unused_ack = bus.ack;
    assign accept     = capture;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            value_q    <= value_next;
            valid_q    <= valid_next;
            overflow_q <= overflow_next;
            lost_q     <= lost_next;
        end
    end

    always_comb begin
        state_next    = state;
        count_next    = count;
        value_next    = value_q;
        overflow_next = overflow_q;
`ifdef CAPTURE_ACK_EN
        valid_next    = valid_q && !bus.ack;
        lost_next     = lost_q && !bus.ack;
`else
        valid_next    = 1'b0;
        lost_next     = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    count_next = '0;
                end
            end
            RUN, SAT: begin
                // A start alongside stop restarts immediately, so back-to-back intervals lose no tick.
                if (bus.stop || bus.start) begin
                    state_next = bus.start ? RUN : IDLE;
                    count_next = '0;
                end else if (state == RUN && bus.enable) begin
                    if (reach) begin
                        state_next = SAT;
                        count_next = MAX;
                    end else begin
                        count_next = sum[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase

        if (accept) begin
            value_next    = sum_hit ? MAX : sum[WIDTH-1:0];
            overflow_next = sum_hit;
            valid_next    = 1'b1;
        end
`ifdef CAPTURE_ACK_EN
        if (capture && !accept) begin
            lost_next = 1'b1;
        end
`endif
    end

    assign bus.value    = value_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
    assign bus.lost     = lost_q;
    assign bus.busy     = (state != IDLE);
endmodule
